// File: rtl/oc8051_ifetch_buf_pkg.sv
// Shared constants and types for the 8051 instruction prefetch queue.
package oc8051_ifetch_buf_pkg;
   localparam int FETCH_W = 3;   // bytes returned by the ROM per fetch
   localparam int PC_W    = 16;
   typedef logic [PC_W-1:0] pc_t;
endpackage

// File: rtl/oc8051_ifetch_fifo.sv
// Byte-wide circular buffer: 3-byte write port, three head read ports, pop of 0..3 bytes.
module oc8051_ifetch_fifo
   import oc8051_ifetch_buf_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int DEPTH_LOG = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 push,
   input  logic [7:0]           wr_b0,
   input  logic [7:0]           wr_b1,
   input  logic [7:0]           wr_b2,
   input  logic [1:0]           pop,
   output logic [7:0]           rd_b0,
   output logic [7:0]           rd_b1,
   output logic [7:0]           rd_b2,
   output logic [DEPTH_LOG:0]   cnt
);
   typedef logic [DEPTH_LOG-1:0] ptr_t;
   typedef logic [DEPTH_LOG:0]   cnt_t;

   logic [7:0] mem_q [DEPTH];
   logic [7:0] mem_d [DEPTH];
   ptr_t       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   cnt_t       cnt_q, cnt_d;
   logic [7:0] head [3];
   logic [7:0] hold_q [3];
   logic [7:0] hold_d [3];

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < 3; i++) begin
         head[i]   = mem_q[rd_ptr_q + ptr_t'(i)];
         hold_d[i] = (cnt_q != '0) ? head[i] : hold_q[i];
      end
      // Flushing drops the tail back onto the head so the outputs keep showing the last bytes.
      if (flush) begin
         wr_ptr_d = rd_ptr_q;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q]            = wr_b0;
            mem_d[wr_ptr_q + ptr_t'(1)] = wr_b1;
            mem_d[wr_ptr_q + ptr_t'(2)] = wr_b2;
            wr_ptr_d = wr_ptr_q + ptr_t'(FETCH_W);
         end
         rd_ptr_d = rd_ptr_q + ptr_t'(pop);
         cnt_d    = cnt_q - cnt_t'(pop) + (push ? cnt_t'(FETCH_W) : cnt_t'(0));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         for (int i = 0; i < 3; i++) hold_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         hold_q   <= hold_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rd_b0 = (cnt_q != '0) ? head[0] : hold_q[0];
   assign rd_b1 = (cnt_q != '0) ? head[1] : hold_q[1];
   assign rd_b2 = (cnt_q != '0) ? head[2] : hold_q[2];
   assign cnt   = cnt_q;
endmodule

// File: rtl/oc8051_ifetch_buf.sv
// Instruction prefetch queue: ROM fetch issue, in-flight capture, branch redirect and
// external-ROM stall in front of a byte FIFO feeding the decoder.
module oc8051_ifetch_buf
   import oc8051_ifetch_buf_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int DEPTH_LOG = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [15:0]          rom_addr,
   input  logic [7:0]           rom_d1,
   input  logic [7:0]           rom_d2,
   input  logic [7:0]           rom_d3,
   input  logic                 rom_ea_int,
   input  logic                 redir,
   input  logic [15:0]          redir_pc,
   input  logic [1:0]           take,
   output logic [7:0]           q_b0,
   output logic [7:0]           q_b1,
   output logic [7:0]           q_b2,
   output logic [DEPTH_LOG:0]   q_cnt,
   output logic [15:0]          q_pc,
   output logic                 ext_stall
);
   typedef logic [DEPTH_LOG:0]   cnt_t;
   typedef logic [DEPTH_LOG+1:0] used_t;

   pc_t        fetch_pc_q, fetch_pc_d, q_pc_q, q_pc_d;
   logic       inflight_q, inflight_d, ext_stall_q, ext_stall_d;
   logic       capture_ok, capture_bad, room, issue;
   used_t      used;
   logic [1:0] take_eff, pop;

   always_comb begin
      take_eff    = (cnt_t'(take) > q_cnt) ? q_cnt[1:0] : take;
      capture_ok  = inflight_q & rom_ea_int & ~redir;
      capture_bad = inflight_q & ~rom_ea_int & ~redir;
      // Reserve space for a fetch still in flight so the queue can never overflow.
      used        = used_t'(q_cnt) + (inflight_q ? used_t'(FETCH_W) : used_t'(0));
      room        = (used <= used_t'(DEPTH - FETCH_W));
      issue       = redir | (~ext_stall_q & ~capture_bad & room);
      rom_addr    = redir ? redir_pc : fetch_pc_q;
      fetch_pc_d  = issue ? rom_addr + pc_t'(FETCH_W) : fetch_pc_q;
      inflight_d  = issue;
      q_pc_d      = q_pc_q + pc_t'(take_eff);
      ext_stall_d = ext_stall_q | capture_bad;
      pop         = take_eff;
      if (redir) begin
         q_pc_d      = redir_pc;
         ext_stall_d = 1'b0;
         pop         = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q  <= '0;
         q_pc_q      <= '0;
         inflight_q  <= 1'b0;
         ext_stall_q <= 1'b0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         q_pc_q      <= q_pc_d;
         inflight_q  <= inflight_d;
         ext_stall_q <= ext_stall_d;
      end
   end

   oc8051_ifetch_fifo #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redir),
      .push  (capture_ok),
      .wr_b0 (rom_d1),
      .wr_b1 (rom_d2),
      .wr_b2 (rom_d3),
      .pop   (pop),
      .rd_b0 (q_b0),
      .rd_b1 (q_b1),
      .rd_b2 (q_b2),
      .cnt   (q_cnt)
   );

   assign q_pc      = q_pc_q;
   assign ext_stall = ext_stall_q;

   take_within_count: assert property (@(posedge clk) disable iff (!rst) cnt_t'(take) <= q_cnt);
endmodule

// File: tb/tb_oc8051_ifetch_buf.sv
// Scoreboarded bench for the prefetch queue: a registered ROM model, directed sequences,
// and a negedge monitor matching every consumed byte and its PC against an expected queue.
module tb_oc8051_ifetch_buf;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] rom_addr;
   logic [7:0]  rom_d1 = 8'h0, rom_d2 = 8'h0, rom_d3 = 8'h0;
   logic        rom_ea_int = 1'b1;
   logic        redir = 1'b0;
   logic [15:0] redir_pc = 16'h0;
   logic [1:0]  take = 2'd0;
   logic [7:0]  q_b0, q_b1, q_b2;
   logic [3:0]  q_cnt;
   logic [15:0] q_pc;
   logic        ext_stall;

   int          checks = 0;
   int          failures = 0;
   logic [23:0] exp_q[$];
   logic [15:0] exp_pc = 16'h0;
   logic [16:0] ea_limit = 17'h10000;

   oc8051_ifetch_buf #(.DEPTH(8), .DEPTH_LOG(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .rom_addr   (rom_addr),
      .rom_d1     (rom_d1),
      .rom_d2     (rom_d2),
      .rom_d3     (rom_d3),
      .rom_ea_int (rom_ea_int),
      .redir      (redir),
      .redir_pc   (redir_pc),
      .take       (take),
      .q_b0       (q_b0),
      .q_b1       (q_b1),
      .q_b2       (q_b2),
      .q_cnt      (q_cnt),
      .q_pc       (q_pc),
      .ext_stall  (ext_stall)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   function automatic logic [7:0] rom_byte(input logic [15:0] a);
      return a[7:0] ^ a[15:8];
   endfunction

   // Registered ROM: address sampled on posedge, data and internal flag valid next cycle.
   always @(posedge clk) begin
      rom_d1     <= rom_byte(rom_addr);
      rom_d2     <= rom_byte(rom_addr + 16'd1);
      rom_d3     <= rom_byte(rom_addr + 16'd2);
      rom_ea_int <= ({1'b0, rom_addr} < ea_limit);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : mon
      logic [23:0] e;
      logic [7:0]  b;
      if (rst && !redir && take != 2'd0) begin
         for (int i = 0; i < int'(take); i++) begin
            b = (i == 0) ? q_b0 : (i == 1) ? q_b1 : q_b2;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_empty actual=consumed byte %0h required=expected entry", b);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc_byte", {8'h0, q_pc + 16'(i), b}, {8'h0, e});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic take_n(input int n);
      take = 2'(n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({exp_pc, rom_byte(exp_pc)});
         exp_pc = exp_pc + 16'd1;
      end
   endtask

   task automatic drain(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         take_n((int'(q_cnt) > 3) ? 3 : int'(q_cnt));
         sample();
         tick();
      end
      take = 2'd0;
   endtask

   task automatic start_redir(input logic [15:0] pc);
      take     = 2'd0;
      redir    = 1'b1;
      redir_pc = pc;
      exp_pc   = pc;
      sample();
      chk("redir_rom_addr", rom_addr, pc);
      tick();
      redir = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : drv
      repeat (3) @(posedge clk);
      sample();
      chk("rst_q_cnt", q_cnt, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_q_pc", q_pc, 0);
      chk("rst_ext_stall", ext_stall, 0);
      chk("rst_q_b0", q_b0, 0);
      tick();
      rst = 1'b1;

      // Fill from 0 with no consumption: fetches at 0 and 3, then holds at 6 bytes.
      sample(); chk("fill_addr0", rom_addr, 16'h0000); tick();
      sample(); chk("fill_addr3", rom_addr, 16'h0003); chk("fill_cnt0", q_cnt, 0); tick();
      sample(); chk("fill_cnt3", q_cnt, 3); tick();
      sample();
      chk("fill_cnt6", q_cnt, 6);
      chk("fill_addr6", rom_addr, 16'h0006);
      chk("fill_q_pc", q_pc, 0);
      chk("fill_b0", q_b0, 8'h00);
      chk("fill_b1", q_b1, 8'h01);
      chk("fill_b2", q_b2, 8'h02);
      tick();
      sample(); chk("full_cnt_hold", q_cnt, 6); chk("full_addr_hold", rom_addr, 16'h0006); tick();

      // Decoder consumes up to 3 bytes per cycle; bytes and PC checked in order.
      drain(12);
      sample(); chk("stream_q_pc", q_pc, exp_pc); tick();

      // Redirect to 0x50, then redirect again to 0x100 while the 0x50 fetch is in flight.
      start_redir(16'h0050);
      take = 2'd0; redir = 1'b1; redir_pc = 16'h0100; exp_pc = 16'h0100;
      sample(); chk("redir2_addr", rom_addr, 16'h0100); chk("redir2_cnt", q_cnt, 0); tick();
      redir = 1'b0;
      sample(); chk("redir_t1_cnt", q_cnt, 0); chk("redir_t1_pc", q_pc, 16'h0100); tick();
      take_n(3);
      sample();
      chk("redir_t2_cnt", q_cnt, 3);
      chk("redir_t2_pc", q_pc, 16'h0100);
      chk("redir_t2_b0", q_b0, 8'h01);
      chk("redir_t2_b1", q_b1, 8'h00);
      chk("redir_t2_b2", q_b2, 8'h03);
      tick();

      // Append and take 2 in the same cycle with 2 bytes queued.
      take_n(1); sample(); chk("app_pre_cnt3", q_cnt, 3); tick();
      take_n(2); sample(); chk("app_pre_cnt2", q_cnt, 2); tick();
      take = 2'd0;
      sample();
      chk("app_cnt", q_cnt, 3);
      chk("app_q_pc", q_pc, 16'h0106);
      chk("app_b0", q_b0, 8'h07);
      tick();
      drain(6);

      // PC wrap at the top of the address space.
      start_redir(16'hFFFE);
      sample(); tick();
      take_n(1); sample(); chk("wrap_cnt", q_cnt, 3); chk("wrap_pc_fffe", q_pc, 16'hFFFE); tick();
      take_n(1); sample(); chk("wrap_pc_ffff", q_pc, 16'hFFFF); tick();
      take_n(1); sample(); chk("wrap_pc_0000", q_pc, 16'h0000); tick();
      drain(4);

      // Fetch crossing into external ROM at 0x200 freezes the fetcher.
      ea_limit = 17'h00200;
      start_redir(16'h01FA);
      sample(); tick();
      sample(); chk("ext_cnt3", q_cnt, 3); tick();
      take_n(3); sample(); chk("ext_cnt6", q_cnt, 6); tick();
      take = 2'd0;
      sample(); chk("ext_pre_stall", ext_stall, 0); chk("ext_pre_cnt", q_cnt, 3); tick();
      sample(); chk("ext_addr_next", rom_addr, 16'h0203); tick();
      take_n(3);
      sample();
      chk("ext_stall_set", ext_stall, 1);
      chk("ext_cnt_kept", q_cnt, 3);
      chk("ext_addr_frozen", rom_addr, 16'h0203);
      tick();
      take = 2'd0;
      sample(); chk("ext_cnt_empty", q_cnt, 0); chk("ext_addr_frozen2", rom_addr, 16'h0203); tick();
      sample(); chk("ext_stall_hold", ext_stall, 1); tick();
      ea_limit = 17'h10000;
      start_redir(16'h0010);
      sample(); chk("ext_cleared", ext_stall, 0); tick();
      take_n(3); sample(); chk("ext_redir_cnt", q_cnt, 3); chk("ext_redir_b0", q_b0, 8'h10); tick();
      take = 2'd0;

      // Reset in the middle of operation, then a clean restart from address 0.
      rst = 1'b0;
      sample(); chk("mid_rst_cnt", q_cnt, 0); chk("mid_rst_pc", q_pc, 0); tick();
      rst = 1'b1;
      exp_pc = 16'h0;
      sample(); chk("restart_cnt_a", q_cnt, 0); tick();
      sample(); chk("restart_cnt_b", q_cnt, 0); tick();
      take_n(3); sample(); chk("restart_cnt_c", q_cnt, 3); chk("restart_b0", q_b0, 8'h00); tick();
      take = 2'd0;
      drain(3);

      chk("sb_leftover", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #100000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
